lcd_rom_streamer: RTL and testbench
===================================

Name: lcd_rom_streamer

Overview:
- Sequences the 16-bit image block ROM.
- Walks a rectangular pixel window (base, width, height, line stride) through ROM addresses and absorbs the ROM's fixed 1-cycle read latency.
- Presents pixels as a valid/ready stream to the LCD write engine.
- Sits between the CPU-side LCD control registers (start/abort/window) and the LCD bus interface.

Parameters:
- ADDR_WIDTH, 17, ROM address width; all address arithmetic is modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 16, pixel width (RGB565).
- DIM_WIDTH, 9, width of the window width/height counters (max 511).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start_i  in  1  one-cycle request; latches the window fields; accepted only in IDLE.
- abort_i  in  1  cancels the current transfer.
- base_addr_i  in  ADDR_WIDTH  ROM address of the window's top-left pixel.
- width_i  in  DIM_WIDTH  pixels per line.
- height_i  in  DIM_WIDTH  number of lines.
- stride_i  in  ADDR_WIDTH  address increment between line starts.
- rom_addr_o  out  ADDR_WIDTH  to ROM addr_i.
- rom_data_i  in  DATA_WIDTH  from ROM data_o; valid 1 cycle after the address is presented.
- pix_valid_o  out  1  stream valid.
- pix_ready_i  in  1  stream ready.
- pix_data_o  out  DATA_WIDTH  pixel.
- pix_eol_o  out  1  last pixel of a line.
- pix_last_o  out  1  last pixel of the window.
- busy_o  out  1  high in RUN or DRAIN.
- done_o  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; FIFO is emptied; the read-pending flag clears.
  - All outputs are 0, including rom_addr_o and pix_data_o.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start_i latches all window fields. col=0, row=0, line_base=base, addr=base.
  - Next state is RUN. If width==0 or height==0, no reads are issued and done_o pulses in the next cycle instead.
- Address output: rom_addr_o = addr register, combinational from the register. The ROM has no enable, so "issue" means the controller commits to capturing rom_data_i next cycle.
- Issue rule (RUN only):
  - Issue in cycle N if (fifo_count + rd_pending − pop_N) < 2, where pop_N = pix_valid_o & pix_ready_i.
  - With pix_ready_i held high, throughput is 1 pixel/cycle.
- Capture: rd_pending is set in the cycle after an issue. In that cycle rom_data_i is pushed into the FIFO with eol/last tags computed at issue time.
- Counter advance, on each issue:
  - If col < width−1: col++, addr++.
  - Else: col=0, row++, line_base += stride, addr = line_base + stride (mod 2^ADDR_WIDTH).
  - Tag eol when col==width−1. Tag last when additionally row==height−1.
  - Issuing the last pixel moves the state to DRAIN.
- DRAIN: no issues. Leave DRAIN after the pop of the pixel tagged last; done_o pulses the following cycle and the state returns to IDLE.
- FIFO: 2 entries holding {data, eol, last}.
  - pix_valid_o = FIFO not empty.
  - Head fields stay stable while valid && !ready.
  - Simultaneous push and pop is legal; the count is unchanged.
- busy_o = state != IDLE. It falls in the same cycle done_o pulses.
- Ignored inputs: start_i outside IDLE is ignored, and window fields are not re-sampled.
- abort_i, any state:
  - Next cycle is IDLE. FIFO and rd_pending are flushed, so pix_valid_o=0 next cycle.
  - No done_o pulse. abort_i has priority over start_i in the same cycle.
- Stride smaller than width (overlapping lines) is legal; addresses follow the arithmetic above.
- Address wrap past 2^ADDR_WIDTH−1 to 0 is silent.

Decomposition:
- Shared package/include holds:
  - State encoding localparams (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2).
  - FIFO depth constant (2).
  - Pixel tag bit positions.
- One sub-module: lcd_pix_fifo2 — 2-entry synchronous FIFO with push/pop/count, synchronous active-low reset and synchronous flush input.

Test Plan:
- Base 0x00100, width 4, height 2, stride 320, ready held 1:
  - rom_addr_o sequence 0x100–0x103, then 0x240–0x243.
  - 8 pixels on 8 consecutive cycles.
  - eol on pixels 4 and 8; last on pixel 8; done_o one cycle after the final handshake.
- Same window, ready toggling 1,0,0,1,…:
  - No pixel lost or duplicated; data matches the ROM model.
  - FIFO never exceeds 2 entries.
  - pix_data_o stable while stalled.
- Width 0, height 5:
  - Zero rom captures, pix_valid_o stays 0.
  - done_o pulses one cycle after start; busy_o pulses high for one cycle.
- Abort in the third pixel of a 16×16 window with the FIFO full:
  - pix_valid_o=0 next cycle; no done_o.
  - A subsequent start re-streams from the new base.
- Base 0x1FFFE, width 4, height 1: addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- start_i pulsed mid-RUN with different fields: ignored, original window completes. Reset mid-DRAIN: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/lcd_rom_streamer_pkg.sv
// Shared encodings for the LCD ROM streamer: FSM states, FIFO depth, pixel tag bit positions.
package lcd_rom_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH   = 2;
  localparam int TAG_EOL_BIT  = 0;
  localparam int TAG_LAST_BIT = 1;
  localparam int TAG_BITS     = 2;

endpackage

// File: rtl/lcd_rom_streamer_pix_fifo2.sv
// Two-entry synchronous pixel FIFO; head visible combinationally, push and pop in the same cycle
// leave the count unchanged, flush empties it in one cycle.
module lcd_pix_fifo2
  import lcd_rom_streamer_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush_i) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push_i) begin
        r_mem[r_wr_ptr] <= push_dat_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop_i) r_rd_ptr <= ~r_rd_ptr;
      if (push_i && !pop_i)      r_count <= r_count + 2'd1;
      else if (!push_i && pop_i) r_count <= r_count - 2'd1;
    end
  end

  assign head_dat_o = r_mem[r_rd_ptr];
  assign count_o    = r_count;

endmodule

// File: rtl/lcd_rom_streamer.sv
// Walks a pixel window through a 1-cycle-latency ROM into a valid/ready stream; first pixel 2 cycles
// after the state enters RUN, then 1/cycle; stalls on !pix_ready_i by holding reads once 2 are in flight.
module lcd_rom_streamer
  import lcd_rom_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16,
  parameter int DIM_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [DIM_WIDTH-1:0]  width_i,
  input  logic [DIM_WIDTH-1:0]  height_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
  output logic [DATA_WIDTH-1:0] pix_data_o,
  output logic                  pix_eol_o,
  output logic                  pix_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam int                    ENTRY_W  = DATA_WIDTH + TAG_BITS;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, r_line_base, r_stride;
  logic [DIM_WIDTH-1:0]  r_col, r_row, r_width, r_height;
  logic                  r_rd_pending, r_pend_eol, r_pend_last, r_done;

  logic [1:0]            w_count;
  logic [ENTRY_W-1:0]    w_head, w_push_dat;
  logic [2:0]            w_occ;
  logic                  w_valid, w_pop, w_start, w_zero_win;
  logic                  w_col_end, w_row_end, w_issue, w_issue_last;
  logic                  w_last_pop, w_done_nxt;

  assign w_valid      = (w_count != 2'd0);
  assign w_pop        = w_valid & pix_ready_i;
  assign w_start      = (r_state == ST_IDLE) & start_i & ~abort_i;
  assign w_zero_win   = (r_width == '0) | (r_height == '0);
  assign w_col_end    = (r_col == r_width - DIM_ONE);
  assign w_row_end    = (r_row == r_height - DIM_ONE);
  // Reads in flight, counting the read whose data lands next cycle, minus this cycle's pop.
  assign w_occ        = {1'b0, w_count} + {2'b00, r_rd_pending} - {2'b00, w_pop};
  assign w_issue      = (r_state == ST_RUN) & ~w_zero_win & ~abort_i & (w_occ < 3'd2);
  assign w_issue_last = w_issue & w_col_end & w_row_end;
  assign w_last_pop   = w_pop & w_head[TAG_LAST_BIT];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: if (start_i) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_zero_win) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_issue_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_last_pop) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (abort_i) begin
      w_state_nxt = ST_IDLE;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_line_base  <= '0;
      r_stride     <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_width      <= '0;
      r_height     <= '0;
      r_rd_pending <= 1'b0;
      r_pend_eol   <= 1'b0;
      r_pend_last  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done       <= w_done_nxt;
      r_rd_pending <= w_issue;
      if (w_start) begin
        r_width     <= width_i;
        r_height    <= height_i;
        r_stride    <= stride_i;
        r_line_base <= base_addr_i;
        r_addr      <= base_addr_i;
        r_col       <= '0;
        r_row       <= '0;
      end else if (w_issue) begin
        r_pend_eol  <= w_col_end;
        r_pend_last <= w_col_end & w_row_end;
        if (w_col_end) begin
          r_col       <= '0;
          r_row       <= r_row + DIM_ONE;
          r_line_base <= r_line_base + r_stride;
          r_addr      <= r_line_base + r_stride;
        end else begin
          r_col  <= r_col + DIM_ONE;
          r_addr <= r_addr + ADDR_ONE;
        end
      end
    end
  end

  assign w_push_dat = {rom_data_i, r_pend_last, r_pend_eol};

  lcd_pix_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (abort_i),
    .push_i    (r_rd_pending),
    .push_dat_i(w_push_dat),
    .pop_i     (w_pop),
    .head_dat_o(w_head),
    .count_o   (w_count)
  );

  assign rom_addr_o  = r_addr;
  assign pix_valid_o = w_valid;
  assign pix_data_o  = w_valid ? w_head[ENTRY_W-1:TAG_BITS] : '0;
  assign pix_eol_o   = w_valid & w_head[TAG_EOL_BIT];
  assign pix_last_o  = w_valid & w_head[TAG_LAST_BIT];
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done;

endmodule

// File: tb/tb_lcd_rom_streamer.sv
// Bench for lcd_rom_streamer: a ROM model plus an expected-pixel queue built from window arithmetic,
// checked every cycle by one monitor, with directed and randomized windows and ready patterns.
module tb_lcd_rom_streamer;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        abort_i;
  logic [16:0] base_addr_i;
  logic [8:0]  width_i;
  logic [8:0]  height_i;
  logic [16:0] stride_i;
  logic [16:0] rom_addr_o;
  logic [15:0] rom_data_i;
  logic        pix_valid_o;
  logic        pix_ready_i;
  logic [15:0] pix_data_o;
  logic        pix_eol_o;
  logic        pix_last_o;
  logic        busy_o;
  logic        done_o;

  lcd_rom_streamer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .base_addr_i(base_addr_i),
    .width_i    (width_i),
    .height_i   (height_i),
    .stride_i   (stride_i),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .pix_valid_o(pix_valid_o),
    .pix_ready_i(pix_ready_i),
    .pix_data_o (pix_data_o),
    .pix_eol_o  (pix_eol_o),
    .pix_last_o (pix_last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  typedef struct {
    logic [15:0] d;
    logic        eol;
    logic        last;
  } pix_t;

  pix_t        exp_q[$];
  logic [16:0] addr_log[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          hs_count, eol_seen, done_count;
  int          first_hs, last_hs, done_cyc;
  int          mode = 0;
  int          phase = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_dat = '0;

  function automatic logic [15:0] rom_fn(input logic [16:0] a);
    logic [31:0] t;
    t = {15'd0, a} * 32'd40503 + 32'h1357;
    return t[15:0] ^ t[24:9];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synchronous ROM: data for the address presented this cycle appears next cycle.
  initial begin
    rom_data_i = '0;
    forever begin
      @(posedge clk);
      rom_data_i <= rom_fn(rom_addr_o);
    end
  end

  initial begin
    pix_ready_i = 0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: pix_ready_i = 1;
        1: begin pix_ready_i = (phase == 0); phase = (phase + 1) % 3; end
        2: pix_ready_i = ($urandom_range(0, 2) != 0);
        default: pix_ready_i = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (busy_o && (addr_log.size() == 0 || addr_log[$] != rom_addr_o))
        addr_log.push_back(rom_addr_o);
      if (pix_valid_o) begin
        if (exp_q.size() == 0) begin
          check("pix_unexpected", {31'd0, pix_valid_o}, 32'd0);
        end else begin
          if (prev_stall) check("hold_data", {16'd0, pix_data_o}, {16'd0, prev_dat});
          check("pix_data", {16'd0, pix_data_o}, {16'd0, exp_q[0].d});
          check("pix_eol", {31'd0, pix_eol_o}, {31'd0, exp_q[0].eol});
          check("pix_last", {31'd0, pix_last_o}, {31'd0, exp_q[0].last});
          if (pix_ready_i) begin
            if (hs_count == 0) first_hs = cyc;
            hs_count++;
            if (pix_eol_o) eol_seen++;
            if (pix_last_o) last_hs = cyc;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_stall = pix_valid_o && !pix_ready_i;
      prev_dat   = pix_data_o;
      if (done_o) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  {15'd0, rom_addr_o}, 32'd0);
    check({tag, "_valid"}, {31'd0, pix_valid_o}, 32'd0);
    check({tag, "_data"},  {16'd0, pix_data_o}, 32'd0);
    check({tag, "_eol"},   {31'd0, pix_eol_o}, 32'd0);
    check({tag, "_last"},  {31'd0, pix_last_o}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
    check({tag, "_done"},  {31'd0, done_o}, 32'd0);
  endtask

  task automatic start_window(input logic [16:0] b, input int w, input int h, input logic [16:0] s);
    pix_t p;
    logic [31:0] a;
    exp_q.delete();
    addr_log.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        a = {15'd0, b} + r * {15'd0, s} + c;
        p.d    = rom_fn(a[16:0]);
        p.eol  = (c == w - 1);
        p.last = (c == w - 1) && (r == h - 1);
        exp_q.push_back(p);
      end
    end
    hs_count = 0; eol_seen = 0; done_count = 0;
    first_hs = 0; last_hs = 0; done_cyc = 0;
    @(posedge clk); #1;
    base_addr_i = b; width_i = w[8:0]; height_i = h[8:0]; stride_i = s;
    start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic run_window(input logic [16:0] b, input int w, input int h, input logic [16:0] s,
                            input bit inject);
    start_window(b, w, h, s);
    for (int k = 0; k < 4000 && done_count == 0; k++) begin
      @(posedge clk); #1;
      start_i = inject && (k == 2);
      if (start_i) begin
        base_addr_i = b + 17'h55; width_i = 9'd7; height_i = 9'd3; stride_i = 17'd1;
      end
    end
    start_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_count, 1);
    check("pix_count", hs_count, w * h);
    check("eol_count", eol_seen, h);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [16:0] exp_a[9];
    logic [31:0] rb, rs;
    rst_n = 0; start_i = 0; abort_i = 0;
    base_addr_i = '0; width_i = '0; height_i = '0; stride_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check_all_zero("idle");

    // Basic 4x2 window at full throughput.
    mode = 0;
    run_window(17'h00100, 4, 2, 17'd320, 0);
    exp_a = '{17'h100, 17'h101, 17'h102, 17'h103, 17'h240, 17'h241, 17'h242, 17'h243, 17'h380};
    check("addr_count", addr_log.size(), 9);
    for (int i = 0; i < 9 && i < addr_log.size(); i++) check("addr_seq", {15'd0, addr_log[i]}, {15'd0, exp_a[i]});
    check("back_to_back", last_hs - first_hs, 7);
    check("done_after_last", done_cyc - last_hs, 1);

    // Same window under a 1,0,0 ready pattern.
    mode = 1;
    run_window(17'h00100, 4, 2, 17'd320, 0);

    // Empty window: one busy cycle then done, never valid.
    mode = 0;
    done_count = 0;
    exp_q.delete();
    @(posedge clk); #1;
    base_addr_i = 17'h00040; width_i = 9'd0; height_i = 9'd5; stride_i = 17'd10; start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    @(negedge clk);
    check("zero_busy", {31'd0, busy_o}, 32'd1);
    check("zero_done_early", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    check("zero_busy_fall", {31'd0, busy_o}, 32'd0);
    check("zero_done", {31'd0, done_o}, 32'd1);
    @(negedge clk);
    check("zero_done_pulse", {31'd0, done_o}, 32'd0);
    check("zero_valid", {31'd0, pix_valid_o}, 32'd0);

    // Abort on the third pixel of a 16x16 window with the FIFO full.
    mode = 0;
    start_window(17'h02000, 16, 16, 17'd16);
    for (int g = 0; g < 100 && hs_count < 2; g++) @(posedge clk);
    mode = 3;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_pre_valid", {31'd0, pix_valid_o}, 32'd1);
    @(posedge clk); #1;
    abort_i = 1;
    @(posedge clk); #1;
    abort_i = 0;
    exp_q.delete();
    @(negedge clk);
    check("abort_valid", {31'd0, pix_valid_o}, 32'd0);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    mode = 0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", done_count, 0);
    mode = 2;
    run_window(17'h05000, 3, 2, 17'd7, 0);

    // Address wrap at the top of the ROM.
    mode = 0;
    run_window(17'h1FFFE, 4, 1, 17'h10, 0);
    exp_a = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001, 17'h0000E, 17'h0, 17'h0, 17'h0, 17'h0};
    check("wrap_addr_count", addr_log.size(), 5);
    for (int i = 0; i < 5 && i < addr_log.size(); i++) check("wrap_addr", {15'd0, addr_log[i]}, {15'd0, exp_a[i]});

    // A start pulse mid-transfer must not disturb the running window.
    mode = 1;
    run_window(17'h00300, 4, 2, 17'd10, 1);

    // Randomized windows, including overlapping lines and wrapping strides.
    mode = 2;
    for (int t = 0; t < 8; t++) begin
      rb = $urandom;
      rs = (t < 4) ? $urandom_range(0, 8) : $urandom;
      run_window(rb[16:0], $urandom_range(1, 6), $urandom_range(1, 4), rs[16:0], 0);
    end

    // Reset while draining with the FIFO holding pixels.
    mode = 3;
    start_window(17'h00777, 2, 1, 17'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("drain_valid", {31'd0, pix_valid_o}, 32'd1);
    check("drain_busy", {31'd0, busy_o}, 32'd1);
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("drain_reset");
    @(posedge clk); #1;
    rst_n = 1;
    exp_q.delete();
    mode = 0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
